// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types, sizing constants and priority encoder for the sprite compositor
// Contents:
//   P_* constants     default geometry; sprite_attr_t field widths follow these
//   sprite_attr_t     per-sprite attribute record {x, y, frame, rgb, en}
//   prio_t / prio_enc lowest-index-wins encoder over the opaque vector
package sprite_pkg;

  localparam int          P_NUM_SPRITES = 4;
  localparam int          P_SPRITE_W    = 16;
  localparam int          P_SPRITE_H    = 16;
  localparam int          P_NUM_FRAMES  = 4;
  localparam int          P_COORD_W     = 10;
  localparam logic [23:0] P_BG_RGB      = 24'hFFFFFF;

  localparam int P_IDX_W     = (P_NUM_SPRITES > 1) ? $clog2(P_NUM_SPRITES) : 1;
  localparam int P_FRAME_W   = (P_NUM_FRAMES > 1) ? $clog2(P_NUM_FRAMES) : 1;
  localparam int P_ROM_DEPTH = P_NUM_FRAMES * P_SPRITE_H;

  typedef struct packed {
    logic [P_COORD_W-1:0] x;
    logic [P_COORD_W-1:0] y;
    logic [P_FRAME_W-1:0] frame;
    logic [23:0]          rgb;
    logic                 en;
  } sprite_attr_t;

  typedef struct packed {
    logic               found;
    logic [P_IDX_W-1:0] idx;
  } prio_t;

  // Scans from the lowest priority upwards so the last hit written is index 0 side.
  function automatic prio_t prio_enc(input logic [P_NUM_SPRITES-1:0] v);
    prio_t r;
    r = '0;
    for (int i = P_NUM_SPRITES - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.found = 1'b1;
        r.idx   = P_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - per-sprite bitmap ROM, one row word per address, 1-cycle synchronous read
// Ports:
//   Clk     in   system clock
//   i_addr  in   frame*SPRITE_H + row
//   o_data  out  row bitmap, bit 0 = leftmost pixel, valid the cycle after i_addr
// Bitmap frames (repeating every 4 frames):
//   0 solid, 1 odd columns opaque, 2 diagonal at column (row+ID) mod SPRITE_W, 3 fully transparent
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int  ID       = 0,
  parameter int  SPRITE_W = P_SPRITE_W,
  parameter int  SPRITE_H = P_SPRITE_H,
  parameter int  DEPTH    = P_ROM_DEPTH,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                Clk,
  input  logic [AW-1:0]       i_addr,
  output logic [SPRITE_W-1:0] o_data
);

  logic [SPRITE_W-1:0] r_data;

  function automatic logic [SPRITE_W-1:0] rom_word(input logic [AW-1:0] addr);
    logic [SPRITE_W-1:0] w;
    int                  row;
    int                  frame;
    row   = int'(addr) % SPRITE_H;
    frame = int'(addr) / SPRITE_H;
    w     = '0;
    for (int c = 0; c < SPRITE_W; c++) begin
      case (frame % 4)
        0:       w[c] = 1'b1;
        1:       w[c] = ((c % 2) == 1);
        2:       w[c] = (((row + ID) % SPRITE_W) == c);
        default: w[c] = 1'b0;
      endcase
    end
    return w;
  endfunction

  always_ff @(posedge Clk) begin
    r_data <= rom_word(i_addr);
  end

  assign o_data = r_data;

endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - pipelined N-sprite colour mapper between VGA timing and DAC
// Ports:
//   Clk, Reset_n            clock, async active-low reset
//   pix_valid, DrawX, DrawY pixel stream in, one pixel per cycle, no back-pressure
//   frame_start             commit shadow attributes to the active set
//   reg_we, reg_idx, reg_x, reg_y, reg_frame, reg_rgb, reg_en   shadow attribute write
//   Red, Green, Blue        registered colour, held while out_valid = 0
//   out_valid               colour belongs to the pixel presented two cycles earlier
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = P_NUM_SPRITES,
  parameter int          SPRITE_W    = P_SPRITE_W,
  parameter int          SPRITE_H    = P_SPRITE_H,
  parameter int          NUM_FRAMES  = P_NUM_FRAMES,
  parameter int          COORD_W     = P_COORD_W,
  parameter logic [23:0] BG_RGB      = P_BG_RGB
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            pix_valid,
  input  logic [COORD_W-1:0]              DrawX,
  input  logic [COORD_W-1:0]              DrawY,
  input  logic                            frame_start,
  input  logic                            reg_we,
  input  logic [$clog2(NUM_SPRITES)-1:0]  reg_idx,
  input  logic [COORD_W-1:0]              reg_x,
  input  logic [COORD_W-1:0]              reg_y,
  input  logic [$clog2(NUM_FRAMES)-1:0]   reg_frame,
  input  logic [23:0]                     reg_rgb,
  input  logic                            reg_en,
  output logic [7:0]                      Red,
  output logic [7:0]                      Green,
  output logic [7:0]                      Blue,
  output logic                            out_valid
);

  localparam int COL_W = $clog2(SPRITE_W);
  localparam int ROW_W = $clog2(SPRITE_H);
  localparam int DEPTH = NUM_FRAMES * SPRITE_H;
  localparam int AW    = $clog2(DEPTH);

  sprite_attr_t r_shadow [NUM_SPRITES];
  sprite_attr_t r_active [NUM_SPRITES];
  sprite_attr_t w_shadow_nxt [NUM_SPRITES];
  sprite_attr_t w_wr_attr;

  logic [SPRITE_W-1:0]    w_row [NUM_SPRITES];
  logic [COL_W-1:0]       w_col [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_hit_vec;
  logic [NUM_SPRITES-1:0] w_opaque;
  prio_t                  w_prio;

  logic                   r_valid_s1;
  logic [NUM_SPRITES-1:0] r_hit_s1;
  logic [COL_W-1:0]       r_col_s1 [NUM_SPRITES];
  logic [23:0]            r_rgb_s1 [NUM_SPRITES];
  logic                   r_out_valid;
  logic [23:0]            r_rgb;

  assign w_wr_attr = '{x: reg_x, y: reg_y, frame: reg_frame, rgb: reg_rgb, en: reg_en};

  // Shadow next-state is shared with the commit path so a same-edge write is committed too.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_shadow_nxt[i] = r_shadow[i];
      if (reg_we && (int'(reg_idx) == i)) begin
        w_shadow_nxt[i] = w_wr_attr;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (frame_start) begin
          r_active[i] <= w_shadow_nxt[i];
        end
      end
    end
  end

  // S0: bounding-box test and ROM address per sprite; S1 comb: opacity from the fetched row.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    logic [COORD_W:0] w_x_end;
    logic [COORD_W:0] w_y_end;
    logic [ROW_W-1:0] w_dy;
    logic [AW-1:0]    w_addr;

    // One extra bit so a sprite near the coordinate max clips instead of wrapping to 0.
    assign w_x_end = {1'b0, r_active[g].x} + (COORD_W+1)'(SPRITE_W);
    assign w_y_end = {1'b0, r_active[g].y} + (COORD_W+1)'(SPRITE_H);

    assign w_hit_vec[g] = r_active[g].en
                        && (DrawX >= r_active[g].x) && ({1'b0, DrawX} < w_x_end)
                        && (DrawY >= r_active[g].y) && ({1'b0, DrawY} < w_y_end);

    assign w_col[g] = COL_W'(DrawX - r_active[g].x);
    assign w_dy     = ROW_W'(DrawY - r_active[g].y);
    assign w_addr   = w_hit_vec[g]
                    ? (AW'(r_active[g].frame) * AW'(SPRITE_H) + AW'(w_dy))
                    : '0;

    sprite_rom #(
      .ID       (g),
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .DEPTH    (DEPTH)
    ) u_rom (
      .Clk    (Clk),
      .i_addr (w_addr),
      .o_data (w_row[g])
    );

    assign w_opaque[g] = r_hit_s1[g] & w_row[g][r_col_s1[g]];
  end

  // S1 registers; colours travel with the pixel so a later commit cannot recolour it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid_s1 <= 1'b0;
      r_hit_s1   <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_col_s1[i] <= '0;
        r_rgb_s1[i] <= '0;
      end
    end else begin
      r_valid_s1 <= pix_valid;
      r_hit_s1   <= w_hit_vec;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_col_s1[i] <= w_col[i];
        r_rgb_s1[i] <= r_active[i].rgb;
      end
    end
  end

  assign w_prio = prio_enc(w_opaque);

  // S2: output colour only advances on valid pixels.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_out_valid <= r_valid_s1;
      if (r_valid_s1) begin
        r_rgb <= w_prio.found ? r_rgb_s1[w_prio.idx] : BG_RGB;
      end
    end
  end

  assign Red       = r_rgb[23:16];
  assign Green     = r_rgb[15:8];
  assign Blue      = r_rgb[7:0];
  assign out_valid = r_out_valid;

endmodule
